sparc_ifu_irferr_ctl: RTL and testbench
=======================================

Name: sparc_ifu_irferr_ctl

Overview:
IFU-side partner of the EXU IRF ECC checker. Supplies ECC enables and error-injection controls to the EXU. Consumes the EXU's M-stage CE/UE reports, register ID, syndrome bit 7 and injection acknowledge. Stages the reports to W, raises the replay and trap requests, and maintains the software-visible error status register, the CE counter and the one-shot injection state machine.

Parameters:
CNT_W, 8, width of saturating CE counter

Ports:
clk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
exu_ifu_ecc_ce_m  in  1  correctable IRF error, M stage
exu_ifu_ecc_ue_m  in  1  uncorrectable IRF error, M stage
exu_ifu_err_reg_m  in  8  {window/gl[2:0], reg[4:0]} of logged operand
exu_ifu_err_synd_7_m  in  1  syndrome bit 7 of logged operand
exu_ifu_inj_ack  in  1  EXU consumed injection (W stage)
ifu_inst_vld_m  in  1  M-stage instruction valid and not killed
asi_wr_inj_vld  in  1  write injection register
asi_wr_ctl_vld  in  1  write control register
asi_clr_status  in  1  clear status register and counter
asi_wr_data  in  32  write data: inj [31]=enable, [7:0]=mask; ctl [1]=nceen, [0]=ceen
ifu_exu_inj_irferr  out  1  injection armed
ifu_exu_ecc_mask  out  8  injection check-bit mask
ifu_exu_disable_ce_e  out  1  ~ceen
ifu_exu_nceen_e  out  1  nceen
ifu_ce_replay_w  out  1  replay request for corrected instruction
ifu_ue_trap_w  out  1  precise UE trap request
ifu_ce_int  out  1  disrupting CE interrupt pulse
ifu_inj_done  out  1  one-cycle pulse when injection completes
err_status  out  13  {vld, ue, ce, meu, synd7, reg[7:0]}
err_ce_cnt  out  CNT_W  saturating CE count

Behaviour:
- Reset values: ceen=1, nceen=1, so disable_ce_e=0 and nceen_e=1. inj FSM in IDLE, mask=0, inj_irferr=0. err_status=0, err_ce_cnt=0. All pulse outputs 0.
- M->W staging: one flop stage for ce, ue, reg, synd7.
  - ce_w = ce_m & inst_vld_m & ~ue_m, registered.
  - ue_w = ue_m & inst_vld_m, registered.
  - All status effects are visible the cycle after W.
- ifu_ce_replay_w = ce_w.
- ifu_ue_trap_w = ue_w & nceen. nceen is the current register value.
- ifu_ce_int = ce_w & ceen, single cycle.
- Status capture: a W-cycle event is ce_w | ue_w.
  - If vld=0: load vld=1, ue, ce, synd7 and reg; meu=0.
  - If vld=1 and the held entry is CE and the event is UE: overwrite with the UE fields and set meu=1.
  - Otherwise, with vld=1: fields hold and meu=1.
- asi_clr_status zeroes err_status and err_ce_cnt.
  - On the same cycle as an event, the clear applies first and the event is then captured as if vld=0.
  - On the same cycle as an event, the counter is loaded with 1 if the event is CE, else 0.
- err_ce_cnt increments on ce_w and saturates at 2^CNT_W-1. It does not wrap.
- Control register: asi_wr_ctl_vld loads ceen=data[0] and nceen=data[1]. The new values appear on the _e outputs the next cycle.
- Injection FSM has two states, IDLE and ARMED.
  - IDLE -> ARMED on asi_wr_inj_vld with data[31]=1; mask loads data[7:0].
  - In ARMED, inj_irferr=1 and mask is driven.
  - ARMED -> IDLE on exu_ifu_inj_ack; ifu_inj_done pulses the same cycle the state leaves ARMED. Mask retained.
  - In ARMED, asi_wr_inj_vld with data[31]=1 reloads the mask and stays ARMED. With data[31]=0 it goes to IDLE and reloads the mask, with no done pulse.
  - Write with enable=1 in the same cycle as ack: the write wins, stays ARMED with the new mask, no done pulse.
  - inj_ack in IDLE is ignored.
- Asynchronous reset mid-operation returns every flop to its reset value immediately. Any in-flight W event is dropped.

Test Plan:
- Reset, then idle -> disable_ce_e=0, nceen_e=1, err_status=0, inj_irferr=0, err_ce_cnt=0.
- CE with reg=8'h2B, synd7=1, inst_vld_m=1 -> next cycle replay_w=1 and ce_int=1; the cycle after, err_status={1,0,1,0,1,8'h2B} and cnt=1.
- CE held, then UE with reg=8'h45 and nceen=1 -> ue_trap_w=1, status overwritten to {1,1,0,1,x,8'h45}. A further CE only increments cnt.
- Inj write 32'h8000_00A5 -> inj_irferr=1, mask=8'hA5. Ack -> done pulse, inj_irferr=0. A second ack gives no pulse.
- Same-cycle ack and re-arm write 32'h8000_003C -> stays armed, mask=8'h3C, no done pulse. Same-cycle clr_status and CE -> status vld=1 and cnt=1.
- 255 CEs then one more (CNT_W=8) -> cnt=8'hFF. ctl write data=0 -> disable_ce_e=1, nceen_e=0. UE with inst_vld_m=0 -> no trap and no status change.

Source files
------------

// File: rtl/sparc_ifu_irferr_ctl_if.sv
// Signal bundle between the IFU IRF error controller and its EXU/ASI neighbours.
// The controller uses the slave modport; the EXU/ASI side (or a bench) drives through master.
interface sparc_ifu_irferr_ctl_if #(
    parameter int CNT_W = 8
);
    logic              exu_ifu_ecc_ce_m;
    logic              exu_ifu_ecc_ue_m;
    logic [7:0]        exu_ifu_err_reg_m;
    logic              exu_ifu_err_synd_7_m;
    logic              exu_ifu_inj_ack;
    logic              ifu_inst_vld_m;
    logic              asi_wr_inj_vld;
    logic              asi_wr_ctl_vld;
    logic              asi_clr_status;
    logic [31:0]       asi_wr_data;
    logic              ifu_exu_inj_irferr;
    logic [7:0]        ifu_exu_ecc_mask;
    logic              ifu_exu_disable_ce_e;
    logic              ifu_exu_nceen_e;
    logic              ifu_ce_replay_w;
    logic              ifu_ue_trap_w;
    logic              ifu_ce_int;
    logic              ifu_inj_done;
    logic [12:0]       err_status;
    logic [CNT_W-1:0]  err_ce_cnt;

    modport master (
        output exu_ifu_ecc_ce_m, exu_ifu_ecc_ue_m, exu_ifu_err_reg_m, exu_ifu_err_synd_7_m,
               exu_ifu_inj_ack, ifu_inst_vld_m, asi_wr_inj_vld, asi_wr_ctl_vld,
               asi_clr_status, asi_wr_data,
        input  ifu_exu_inj_irferr, ifu_exu_ecc_mask, ifu_exu_disable_ce_e, ifu_exu_nceen_e,
               ifu_ce_replay_w, ifu_ue_trap_w, ifu_ce_int, ifu_inj_done, err_status, err_ce_cnt
    );

    modport slave (
        input  exu_ifu_ecc_ce_m, exu_ifu_ecc_ue_m, exu_ifu_err_reg_m, exu_ifu_err_synd_7_m,
               exu_ifu_inj_ack, ifu_inst_vld_m, asi_wr_inj_vld, asi_wr_ctl_vld,
               asi_clr_status, asi_wr_data,
        output ifu_exu_inj_irferr, ifu_exu_ecc_mask, ifu_exu_disable_ce_e, ifu_exu_nceen_e,
               ifu_ce_replay_w, ifu_ue_trap_w, ifu_ce_int, ifu_inj_done, err_status, err_ce_cnt
    );
endinterface

// File: rtl/sparc_ifu_irferr_ctl.sv
// IFU-side IRF ECC control: stages EXU CE/UE reports to W, raises replay/trap/interrupt,
// keeps the error status register and CE counter, and runs the one-shot injection FSM.
module sparc_ifu_irferr_ctl #(
    parameter int CNT_W = 8
) (
    input logic                   clk,
    input logic                   arst_l,
    sparc_ifu_irferr_ctl_if.slave bus
);

    localparam logic [0:0] INJ_IDLE  = 1'b0;
    localparam logic [0:0] INJ_ARMED = 1'b1;

    logic             ceW_q, ueW_q, synd7W_q;
    logic [7:0]       errRegW_q;
    logic             ceen_q, nceen_q;
    logic [0:0]       injState_q, injState_d;
    logic [7:0]       injMask_q, injMask_d;
    logic [12:0]      status_q, status_d, statusBase;
    logic [CNT_W-1:0] ceCnt_q, ceCnt_d, ceCntBase;
    logic             wEvent;
    logic             injWrEn;
    logic             unusedDataBits;

    assign unusedDataBits = ^bus.asi_wr_data[30:8];
    assign injWrEn        = bus.asi_wr_data[31];
    assign wEvent         = ceW_q | ueW_q;

    // A UE in the same report suppresses the CE; killed instructions report nothing.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ceW_q     <= 1'b0;
            ueW_q     <= 1'b0;
            synd7W_q  <= 1'b0;
            errRegW_q <= 8'h00;
        end else begin
            ceW_q     <= bus.exu_ifu_ecc_ce_m & bus.ifu_inst_vld_m & ~bus.exu_ifu_ecc_ue_m;
            ueW_q     <= bus.exu_ifu_ecc_ue_m & bus.ifu_inst_vld_m;
            synd7W_q  <= bus.exu_ifu_err_synd_7_m;
            errRegW_q <= bus.exu_ifu_err_reg_m;
        end
    end

    // Clear is applied before the W event so a coincident event lands in an empty register.
    always_comb begin
        statusBase = bus.asi_clr_status ? 13'h0000 : status_q;
        status_d   = statusBase;
        if (wEvent) begin
            if (!statusBase[12]) begin
                status_d = {1'b1, ueW_q, ceW_q, 1'b0, synd7W_q, errRegW_q};
            end else if (statusBase[10] && ueW_q) begin
                status_d = {1'b1, 1'b1, 1'b0, 1'b1, synd7W_q, errRegW_q};
            end else begin
                status_d[9] = 1'b1;
            end
        end
    end

    always_comb begin
        ceCntBase = bus.asi_clr_status ? '0 : ceCnt_q;
        ceCnt_d   = ceCntBase;
        if (ceW_q && (ceCntBase != '1)) begin
            ceCnt_d = ceCntBase + CNT_W'(1);
        end
    end

    // Any injection write wins over a coincident ack, so no done pulse is raised then.
    always_comb begin
        injState_d = injState_q;
        injMask_d  = injMask_q;
        if (bus.asi_wr_inj_vld) begin
            injMask_d  = bus.asi_wr_data[7:0];
            injState_d = injWrEn ? INJ_ARMED : INJ_IDLE;
        end else if ((injState_q == INJ_ARMED) && bus.exu_ifu_inj_ack) begin
            injState_d = INJ_IDLE;
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ceen_q     <= 1'b1;
            nceen_q    <= 1'b1;
            injState_q <= INJ_IDLE;
            injMask_q  <= 8'h00;
            status_q   <= 13'h0000;
            ceCnt_q    <= '0;
        end else begin
            if (bus.asi_wr_ctl_vld) begin
                ceen_q  <= bus.asi_wr_data[0];
                nceen_q <= bus.asi_wr_data[1];
            end
            injState_q <= injState_d;
            injMask_q  <= injMask_d;
            status_q   <= status_d;
            ceCnt_q    <= ceCnt_d;
        end
    end

    assign bus.ifu_exu_inj_irferr   = (injState_q == INJ_ARMED);
    assign bus.ifu_exu_ecc_mask     = injMask_q;
    assign bus.ifu_exu_disable_ce_e = ~ceen_q;
    assign bus.ifu_exu_nceen_e      = nceen_q;
    assign bus.ifu_ce_replay_w      = ceW_q;
    assign bus.ifu_ue_trap_w        = ueW_q & nceen_q;
    assign bus.ifu_ce_int           = ceW_q & ceen_q;
    assign bus.ifu_inj_done         = (injState_q == INJ_ARMED) & bus.exu_ifu_inj_ack &
                                      ~bus.asi_wr_inj_vld;
    assign bus.err_status           = status_q;
    assign bus.err_ce_cnt           = ceCnt_q;

endmodule

// File: tb/tb_sparc_ifu_irferr_ctl.sv
// Scoreboard bench for sparc_ifu_irferr_ctl: directed scenarios then random traffic,
// every cycle checked against a behavioural model through an expected-value queue.
module tb_sparc_ifu_irferr_ctl;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit        ceM, ueM, synd7, vldM, ack, wrInj, wrCtl, clr;
        bit [7:0]  regId;
        bit [31:0] data;
    } stim_t;

    typedef struct {
        bit        inj, disCe, nceenE, replay, trap, ceInt, done;
        bit [7:0]  mask;
        bit [12:0] status;
        bit [CNT_W-1:0] cnt;
    } expect_t;

    logic clk;
    logic arst_l;
    int   total;
    int   bad;
    expect_t expQ[$];

    sparc_ifu_irferr_ctl_if #(.CNT_W(CNT_W)) tbIf ();

    sparc_ifu_irferr_ctl #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .arst_l (arst_l),
        .bus    (tbIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, kept as plain architectural quantities.
    bit        mPendCe, mPendUe, mPendSynd;
    bit [7:0]  mPendReg;
    bit        mCeen, mNceen, mArmed;
    bit [7:0]  mMask;
    bit        sVld, sUe, sCe, sMeu, sSynd;
    bit [7:0]  sReg;
    int        mCnt;

    task automatic modelReset();
        mPendCe = 0; mPendUe = 0; mPendSynd = 0; mPendReg = 0;
        mCeen = 1; mNceen = 1; mArmed = 0; mMask = 0;
        sVld = 0; sUe = 0; sCe = 0; sMeu = 0; sSynd = 0; sReg = 0;
        mCnt = 0;
    endtask

    function automatic expect_t modelOutputs(input stim_t s);
        expect_t e;
        e.inj    = mArmed;
        e.mask   = mMask;
        e.disCe  = !mCeen;
        e.nceenE = mNceen;
        e.replay = mPendCe;
        e.trap   = mPendUe && mNceen;
        e.ceInt  = mPendCe && mCeen;
        e.done   = mArmed && s.ack && !s.wrInj;
        e.status = {sVld, sUe, sCe, sMeu, sSynd, sReg};
        e.cnt    = CNT_W'(mCnt);
        return e;
    endfunction

    task automatic modelAdvance(input stim_t s);
        if (s.clr) begin
            sVld = 0; sUe = 0; sCe = 0; sMeu = 0; sSynd = 0; sReg = 0;
            mCnt = 0;
        end
        if (mPendCe || mPendUe) begin
            if (!sVld) begin
                sVld = 1; sUe = mPendUe; sCe = mPendCe; sMeu = 0; sSynd = mPendSynd; sReg = mPendReg;
            end else if (sCe && mPendUe) begin
                sUe = 1; sCe = 0; sMeu = 1; sSynd = mPendSynd; sReg = mPendReg;
            end else begin
                sMeu = 1;
            end
        end
        if (mPendCe && mCnt < CNT_MAX) mCnt = mCnt + 1;
        if (s.wrCtl) begin
            mCeen  = s.data[0];
            mNceen = s.data[1];
        end
        if (s.wrInj) begin
            mMask  = s.data[7:0];
            mArmed = s.data[31];
        end else if (mArmed && s.ack) begin
            mArmed = 0;
        end
        mPendUe   = s.ueM && s.vldM;
        mPendCe   = s.ceM && s.vldM && !s.ueM;
        mPendReg  = s.regId;
        mPendSynd = s.synd7;
    endtask

    task automatic driveInputs(input stim_t s);
        tbIf.exu_ifu_ecc_ce_m     = s.ceM;
        tbIf.exu_ifu_ecc_ue_m     = s.ueM;
        tbIf.exu_ifu_err_reg_m    = s.regId;
        tbIf.exu_ifu_err_synd_7_m = s.synd7;
        tbIf.exu_ifu_inj_ack      = s.ack;
        tbIf.ifu_inst_vld_m       = s.vldM;
        tbIf.asi_wr_inj_vld       = s.wrInj;
        tbIf.asi_wr_ctl_vld       = s.wrCtl;
        tbIf.asi_clr_status       = s.clr;
        tbIf.asi_wr_data          = s.data;
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // One clock of stimulus: drive, record the expected outputs for this cycle, advance the model.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        driveInputs(s);
        expQ.push_back(modelOutputs(s));
        modelAdvance(s);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        arst_l = 1'b0;
        driveInputs(idleStim());
        modelReset();
        expQ.push_back(modelOutputs(idleStim()));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleStim());
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        cmp("inj_irferr", 32'(tbIf.ifu_exu_inj_irferr),   32'(e.inj));
        cmp("ecc_mask",   32'(tbIf.ifu_exu_ecc_mask),     32'(e.mask));
        cmp("disable_ce", 32'(tbIf.ifu_exu_disable_ce_e), 32'(e.disCe));
        cmp("nceen_e",    32'(tbIf.ifu_exu_nceen_e),      32'(e.nceenE));
        cmp("ce_replay",  32'(tbIf.ifu_ce_replay_w),      32'(e.replay));
        cmp("ue_trap",    32'(tbIf.ifu_ue_trap_w),        32'(e.trap));
        cmp("ce_int",     32'(tbIf.ifu_ce_int),           32'(e.ceInt));
        cmp("inj_done",   32'(tbIf.ifu_inj_done),         32'(e.done));
        cmp("err_status", 32'(tbIf.err_status),           32'(e.status));
        cmp("ce_cnt",     32'(tbIf.err_ce_cnt),           32'(e.cnt));
    endtask

    // Monitor: the DUT presents outputs every cycle, so each negedge retires one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) checkOutput(expQ.pop_front());
        end
    end

    function automatic stim_t mkErr(input bit ce, input bit ue, input bit [7:0] r, input bit s7,
                                    input bit vld);
        stim_t s;
        s = idleStim();
        s.ceM = ce; s.ueM = ue; s.regId = r; s.synd7 = s7; s.vldM = vld;
        return s;
    endfunction

    function automatic stim_t mkInj(input bit [31:0] d, input bit ack);
        stim_t s;
        s = idleStim();
        s.wrInj = 1'b1; s.data = d; s.ack = ack;
        return s;
    endfunction

    stim_t st;

    initial begin
        total  = 0;
        bad    = 0;
        arst_l = 1'b0;
        driveInputs(idleStim());
        modelReset();
        applyReset();
        idleCycles(2);
        @(negedge clk);
        cmp("rst disable_ce", 32'(tbIf.ifu_exu_disable_ce_e), 32'd0);
        cmp("rst nceen_e",    32'(tbIf.ifu_exu_nceen_e),      32'd1);
        cmp("rst status",     32'(tbIf.err_status),           32'd0);
        cmp("rst cnt",        32'(tbIf.err_ce_cnt),           32'd0);

        applyStimulus(mkErr(1, 0, 8'h2B, 1, 1));
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("ce replay",  32'(tbIf.ifu_ce_replay_w), 32'd1);
        cmp("ce int",     32'(tbIf.ifu_ce_int),      32'd1);
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("ce status",  32'(tbIf.err_status), 32'h152B);
        cmp("ce cnt",     32'(tbIf.err_ce_cnt), 32'd1);

        applyStimulus(mkErr(0, 1, 8'h45, 0, 1));
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("ue trap", 32'(tbIf.ifu_ue_trap_w), 32'd1);
        applyStimulus(mkErr(1, 0, 8'h07, 1, 1));
        @(negedge clk);
        cmp("ue status", 32'(tbIf.err_status), 32'h1A45);
        idleCycles(2);
        @(negedge clk);
        cmp("ce after ue status", 32'(tbIf.err_status), 32'h1A45);
        cmp("ce after ue cnt",    32'(tbIf.err_ce_cnt), 32'd2);

        applyStimulus(mkInj(32'h8000_00A5, 0));
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("armed", 32'(tbIf.ifu_exu_inj_irferr), 32'd1);
        cmp("mask",  32'(tbIf.ifu_exu_ecc_mask),   32'hA5);
        st = idleStim(); st.ack = 1'b1;
        applyStimulus(st);
        @(negedge clk);
        cmp("done pulse", 32'(tbIf.ifu_inj_done), 32'd1);
        applyStimulus(st);
        @(negedge clk);
        cmp("disarmed",    32'(tbIf.ifu_exu_inj_irferr), 32'd0);
        cmp("second ack",  32'(tbIf.ifu_inj_done),       32'd0);

        applyStimulus(mkInj(32'h8000_00A5, 0));
        applyStimulus(mkInj(32'h8000_003C, 1));
        @(negedge clk);
        cmp("rearm no done", 32'(tbIf.ifu_inj_done), 32'd0);
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("rearm armed", 32'(tbIf.ifu_exu_inj_irferr), 32'd1);
        cmp("rearm mask",  32'(tbIf.ifu_exu_ecc_mask),   32'h3C);

        applyStimulus(mkErr(1, 0, 8'h11, 0, 1));
        st = idleStim(); st.clr = 1'b1;
        applyStimulus(st);
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("clr+ce status", 32'(tbIf.err_status), 32'h1411);
        cmp("clr+ce cnt",    32'(tbIf.err_ce_cnt), 32'd1);

        for (int i = 0; i < 256; i++) applyStimulus(mkErr(1, 0, 8'h22, 1, 1));
        idleCycles(2);
        @(negedge clk);
        cmp("cnt saturate", 32'(tbIf.err_ce_cnt), 32'hFF);

        applyStimulus(mkErr(0, 1, 8'h33, 1, 0));
        idleCycles(2);
        @(negedge clk);
        cmp("killed ue status", 32'(tbIf.err_status), 32'h1611);

        st = idleStim(); st.wrCtl = 1'b1; st.data = 32'h0;
        applyStimulus(st);
        applyStimulus(idleStim());
        @(negedge clk);
        cmp("ctl disable_ce", 32'(tbIf.ifu_exu_disable_ce_e), 32'd1);
        cmp("ctl nceen_e",    32'(tbIf.ifu_exu_nceen_e),      32'd0);

        applyStimulus(mkErr(1, 0, 8'h44, 0, 1));
        applyReset();
        idleCycles(2);
        @(negedge clk);
        cmp("reset drops event", 32'(tbIf.err_status), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                st = idleStim();
                st.vldM  = ($urandom_range(0, 3) != 0);
                st.ceM   = ($urandom_range(0, 2) == 0);
                st.ueM   = ($urandom_range(0, 7) == 0);
                st.regId = 8'($urandom);
                st.synd7 = 1'($urandom);
                st.ack   = ($urandom_range(0, 3) == 0);
                st.wrInj = ($urandom_range(0, 7) == 0);
                st.wrCtl = ($urandom_range(0, 15) == 0);
                st.clr   = ($urandom_range(0, 31) == 0);
                st.data  = $urandom;
                applyStimulus(st);
            end
        end
        idleCycles(2);
        @(negedge clk);
        @(negedge clk);
        cmp("queue drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
